// File: rtl/wired_mul_pipe_if.sv
// Request/response bundle for wired_mul_pipe.
//   slave  : the multiplier's view (takes requests, drives responses)
//   master : the issue-queue / writeback side (drives requests, takes responses)
// Signals: flush_i, valid_i/ready_o/op_i/r0_i/r1_i/wid_i (request),
//          valid_o/ready_i/wid_o/result_o (response), busy_o (any op in flight).
interface wired_mul_pipe_if #(
  parameter int XLEN  = 32,
  parameter int WID_W = 6
);
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       op_i;
  logic [XLEN-1:0]  r0_i;
  logic [XLEN-1:0]  r1_i;
  logic [WID_W-1:0] wid_i;
  logic             valid_o;
  logic             ready_i;
  logic [WID_W-1:0] wid_o;
  logic [XLEN-1:0]  result_o;
  logic             busy_o;

  modport slave (
    input  flush_i, valid_i, op_i, r0_i, r1_i, wid_i, ready_i,
    output ready_o, valid_o, wid_o, result_o, busy_o
  );

  modport master (
    output flush_i, valid_i, op_i, r0_i, r1_i, wid_i, ready_i,
    input  ready_o, valid_o, wid_o, result_o, busy_o
  );
endinterface

// File: rtl/wired_mul_pipe.sv
// Pipelined XLEN x XLEN integer multiplier (MUL/MULH/MULHSU/MULHU) for the MDU.
// Slot 0 holds sign-extended operands, slot 1 the 2*XLEN product, further slots
// retime. Each slot advances independently so bubbles collapse under backpressure.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset (clears valid bits only)
//   bus    wired_mul_pipe_if.slave: request in, response out, flush, busy
module wired_mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int WID_W  = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  wired_mul_pipe_if.slave bus
);
  localparam int LAST = STAGES - 1;
  localparam int PW   = 2 * XLEN;

  logic [STAGES-1:0]             vld_pipe;
  logic [STAGES-1:0]             adv;
  logic [XLEN:0]                 a_q, b_q;
  logic [PW-1:0]                 a_ext, b_ext, mul_lo;
  logic [STAGES-1:0][1:0]        op_q;
  logic [STAGES-1:0][WID_W-1:0]  wid_q;
  logic [STAGES-1:1][PW-1:0]     prod_q;
  logic [XLEN-1:0]               sel;
  logic                          sa, sb;

  // adv[k] = !v[k] | adv[k+1], unrolled: slot k may move when the output is
  // taken or any slot from k to the end is empty (a bubble to collapse into).
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    assign adv[k] = bus.ready_i | ~(&vld_pipe[LAST:k]);
  end

  // Extra sign bit: rs1 signed unless MULHU, rs2 signed only for MUL/MULH.
  assign sa = bus.r0_i[XLEN-1] & (bus.op_i != 2'b11);
  assign sb = bus.r1_i[XLEN-1] & ~bus.op_i[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (bus.flush_i) begin
      vld_pipe <= '0;
    end else begin
      if (adv[0]) vld_pipe[0] <= bus.valid_i;
      for (int k = 1; k < STAGES; k++)
        if (adv[k]) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // (XLEN+1)x(XLEN+1) signed product; only the low PW bits are kept, so the
  // operands are sign-extended to PW and multiplied modulo 2^PW.
  assign a_ext  = {{(PW-XLEN-1){a_q[XLEN]}}, a_q};
  assign b_ext  = {{(PW-XLEN-1){b_q[XLEN]}}, b_q};
  assign mul_lo = a_ext * b_ext;

  // Data path carries no reset; stale contents are masked by the valid bits.
  always_ff @(posedge clk) begin
    if (adv[0]) begin
      a_q      <= {sa, bus.r0_i};
      b_q      <= {sb, bus.r1_i};
      op_q[0]  <= bus.op_i;
      wid_q[0] <= bus.wid_i;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        op_q[k]  <= op_q[k-1];
        wid_q[k] <= wid_q[k-1];
      end
    end
    if (adv[1]) prod_q[1] <= mul_lo;
    for (int k = 2; k < STAGES; k++)
      if (adv[k]) prod_q[k] <= prod_q[k-1];
  end

  assign sel = (op_q[LAST] == 2'b00) ? prod_q[LAST][XLEN-1:0] : prod_q[LAST][PW-1:XLEN];

  assign bus.valid_o  = vld_pipe[LAST];
  assign bus.result_o = vld_pipe[LAST] ? sel : '0;
  assign bus.wid_o    = vld_pipe[LAST] ? wid_q[LAST] : '0;
  assign bus.busy_o   = |vld_pipe;
  assign bus.ready_o  = adv[0];
endmodule

// File: tb/tb_wired_mul_pipe.sv
// Self-checking bench for wired_mul_pipe: a 32-bit/3-stage and a 64-bit/4-stage
// instance, driven at negedge and observed 1ns later, against an arithmetic
// reference model and an in-order expectation queue.
module tb_wired_mul_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wired_mul_pipe_if #(.XLEN(32), .WID_W(6)) b32 ();
  wired_mul_pipe_if #(.XLEN(64), .WID_W(6)) b64 ();

  wired_mul_pipe #(.XLEN(32), .STAGES(3), .WID_W(6)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  wired_mul_pipe #(.XLEN(64), .STAGES(4), .WID_W(6)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  typedef struct {
    logic [5:0]  wid;
    logic [63:0] res;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  // Reference: interpret operands per RISC-V mode as mathematical integers,
  // multiply exactly, then pick the low or high XLEN bits.
  function automatic logic [63:0] ref_mul(input int xlen, input logic [1:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [131:0] sa, sb, p;
    logic [131:0] r;
    logic [63:0]  mask;
    sa = $signed({68'd0, a});
    sb = $signed({68'd0, b});
    if (op != 2'b11 && a[xlen-1]) sa = sa - (132'sd1 <<< xlen);
    if ((op == 2'b00 || op == 2'b01) && b[xlen-1]) sb = sb - (132'sd1 <<< xlen);
    p = sa * sb;
    r = (op == 2'b00) ? p : (p >>> xlen);
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xlen) - 64'd1);
    return r[63:0] & mask;
  endfunction

  task automatic drive32(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] w, input logic rdy, input logic fl);
    b32.valid_i = v; b32.op_i = op; b32.r0_i = a; b32.r1_i = b;
    b32.wid_i = w; b32.ready_i = rdy; b32.flush_i = fl;
  endtask

  task automatic drive64(input logic v, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] w, input logic rdy, input logic fl);
    b64.valid_i = v; b64.op_i = op; b64.r0_i = a; b64.r1_i = b;
    b64.wid_i = w; b64.ready_i = rdy; b64.flush_i = fl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive32(0, 2'b00, 0, 0, 0, 0, 0);
    drive64(0, 2'b00, 0, 0, 0, 1, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({b32.valid_o, b32.busy_o, b32.ready_o} !== 3'b001) begin
      failures++; $display("FAIL reset32_ctl got v/busy/rdy=%b exp=001", {b32.valid_o, b32.busy_o, b32.ready_o});
    end
    checks++;
    if ({b32.wid_o, b32.result_o} !== 38'd0) begin
      failures++; $display("FAIL reset32_data got wid=%h res=%h exp=0", b32.wid_o, b32.result_o);
    end
    checks++;
    if ({b64.valid_o, b64.busy_o, b64.result_o} !== 66'd0) begin
      failures++; $display("FAIL reset64 got v=%b busy=%b res=%h exp=0", b64.valid_o, b64.busy_o, b64.result_o);
    end
    rst_n = 1'b1;
  endtask

  // T1: directed mode corner cases, one op at a time, also checks latency.
  task automatic test_t1();
    logic [1:0]  op[5]  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10};
    logic [31:0] av[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2};
    logic [31:0] bv[5]  = '{32'h2, 32'h2, 32'h2, 32'h2, 32'hFFFFFFFF};
    logic [31:0] ex[5]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h1};
    int lat;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive32(1, op[i], av[i], bv[i], 6'(i), 1, 0);
      #1;
      lat = 0;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
        @(negedge clk);
        b32.valid_i = 1'b0;
        #1;
        if (b32.valid_o) lat = c;
      end
      checks++;
      if (lat != 3) begin
        failures++; $display("FAIL t1_latency32 op=%0d got=%0d exp=3", i, lat);
      end
      checks++;
      if (lat != 0 && {b32.wid_o, b32.result_o} !== {6'(i), ex[i]}) begin
        failures++; $display("FAIL t1_result32 op=%0d got wid=%0d res=%h exp wid=%0d res=%h", i, b32.wid_o, b32.result_o, i, ex[i]);
      end
    end
  endtask

  // T2: 8 random ops back-to-back, output window must be cycles 3..10.
  task automatic test_back_to_back();
    logic [1:0] op; logic [31:0] a, b; exp_t e;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      drive32(c < 8, op, a, b, 6'(c), 1, 0);
      #1;
      if (c < 8) begin
        checks++;
        if (b32.ready_o !== 1'b1) begin
          failures++; $display("FAIL t2_ready32 cycle=%0d got=%b exp=1", c, b32.ready_o);
        end
        q32.push_back('{wid: 6'(c), res: ref_mul(32, op, {32'd0, a}, {32'd0, b})});
      end
      checks++;
      if (b32.valid_o !== (c >= 3 && c < 11)) begin
        failures++; $display("FAIL t2_valid32 cycle=%0d got=%b exp=%b", c, b32.valid_o, (c >= 3 && c < 11));
      end
      if (b32.valid_o && q32.size() > 0) begin
        e = q32.pop_front();
        checks++;
        if ({b32.wid_o, b32.result_o} !== {e.wid, e.res[31:0]}) begin
          failures++; $display("FAIL t2_data32 cycle=%0d got wid=%0d res=%h exp wid=%0d res=%h", c, b32.wid_o, b32.result_o, e.wid, e.res[31:0]);
        end
      end
    end
    checks++;
    if (q32.size() != 0) begin
      failures++; $display("FAIL t2_drain32 got left=%0d exp=0", q32.size());
    end
    q32.delete();
  endtask

  // T3 (stalled output) and T4 (bubble collapse) share this drain: keep
  // offering the pending ops with ready_i=1 and match every response in order.
  task automatic test_stall();
    logic [1:0] op[5]; logic [31:0] av[5], bv[5]; exp_t e;
    int idx = 0, outs = 0;
    for (int i = 0; i < 5; i++) begin
      op[i] = 2'($urandom_range(0, 3)); av[i] = $urandom; bv[i] = $urandom;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive32(1, op[idx], av[idx], bv[idx], 6'(8 + idx), 0, 0);
      #1;
      if (c >= 3) begin
        checks++;
        if (b32.valid_o !== 1'b1 || {b32.wid_o, b32.result_o} !== {q32[0].wid, q32[0].res[31:0]}) begin
          failures++; $display("FAIL t3_hold32 cycle=%0d got v=%b wid=%0d res=%h exp v=1 wid=%0d res=%h", c, b32.valid_o, b32.wid_o, b32.result_o, q32[0].wid, q32[0].res[31:0]);
        end
      end
      if (b32.ready_o) begin
        q32.push_back('{wid: 6'(8 + idx), res: ref_mul(32, op[idx], {32'd0, av[idx]}, {32'd0, bv[idx]})});
        idx++;
      end
    end
    checks++;
    if (idx != 3 || b32.ready_o !== 1'b0) begin
      failures++; $display("FAIL t3_accept32 got accepted=%0d ready=%b exp accepted=3 ready=0", idx, b32.ready_o);
    end
    for (int c = 0; c < 30 && outs < 5; c++) begin
      @(negedge clk);
      if (idx < 5) drive32(1, op[idx], av[idx], bv[idx], 6'(8 + idx), 1, 0);
      else         drive32(0, 2'b00, 0, 0, 0, 1, 0);
      #1;
      if (b32.valid_i && b32.ready_o) begin
        q32.push_back('{wid: 6'(8 + idx), res: ref_mul(32, op[idx], {32'd0, av[idx]}, {32'd0, bv[idx]})});
        idx++;
      end
      if (b32.valid_o) begin
        outs++;
        checks++;
        if (q32.size() == 0) begin
          failures++; $display("FAIL t3_extra32 got wid=%0d exp none", b32.wid_o);
        end else begin
          e = q32.pop_front();
          if ({b32.wid_o, b32.result_o} !== {e.wid, e.res[31:0]}) begin
            failures++; $display("FAIL t3_data32 got wid=%0d res=%h exp wid=%0d res=%h", b32.wid_o, b32.result_o, e.wid, e.res[31:0]);
          end
        end
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++;
      if (b32.valid_o !== 1'b0) begin
        failures++; $display("FAIL t3_dup32 got valid=%b wid=%0d exp valid=0", b32.valid_o, b32.wid_o);
      end
    end
    checks++;
    if (outs != 5) begin
      failures++; $display("FAIL t3_count32 got=%0d exp=5", outs);
    end
    q32.delete();
  endtask

  task automatic test_bubble();
    logic [1:0] op[4]; logic [31:0] av[4], bv[4]; exp_t e;
    int idx = 0, outs = 0;
    logic offer;
    for (int i = 0; i < 4; i++) begin
      op[i] = 2'($urandom_range(0, 3)); av[i] = $urandom; bv[i] = $urandom;
    end
    // A at c0, idle c1, B at c2, idle c3/c4, C at c5, D offered at c6.
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      offer = (c == 0 || c == 2 || c >= 5);
      drive32(offer, op[idx], av[idx], bv[idx], 6'(20 + idx), 0, 0);
      #1;
      checks++;
      if (b32.ready_o !== (c <= 5)) begin
        failures++; $display("FAIL t4_ready32 cycle=%0d got=%b exp=%b", c, b32.ready_o, (c <= 5));
      end
      if (c == 4) begin
        checks++;
        if ({b32.valid_o, b32.busy_o, b32.wid_o} !== {2'b11, 6'd20}) begin
          failures++; $display("FAIL t4_held32 got v=%b busy=%b wid=%0d exp v=1 busy=1 wid=20", b32.valid_o, b32.busy_o, b32.wid_o);
        end
      end
      if (offer && b32.ready_o) begin
        q32.push_back('{wid: 6'(20 + idx), res: ref_mul(32, op[idx], {32'd0, av[idx]}, {32'd0, bv[idx]})});
        idx++;
      end
    end
    for (int c = 0; c < 30 && outs < 4; c++) begin
      @(negedge clk);
      if (idx < 4) drive32(1, op[idx], av[idx], bv[idx], 6'(20 + idx), 1, 0);
      else         drive32(0, 2'b00, 0, 0, 0, 1, 0);
      #1;
      if (b32.valid_i && b32.ready_o) begin
        q32.push_back('{wid: 6'(20 + idx), res: ref_mul(32, op[idx], {32'd0, av[idx]}, {32'd0, bv[idx]})});
        idx++;
      end
      if (b32.valid_o) begin
        outs++;
        checks++;
        if (q32.size() == 0) begin
          failures++; $display("FAIL t4_extra32 got wid=%0d exp none", b32.wid_o);
        end else begin
          e = q32.pop_front();
          if ({b32.wid_o, b32.result_o} !== {e.wid, e.res[31:0]}) begin
            failures++; $display("FAIL t4_data32 got wid=%0d res=%h exp wid=%0d res=%h", b32.wid_o, b32.result_o, e.wid, e.res[31:0]);
          end
        end
      end
    end
    checks++;
    if (outs != 4) begin
      failures++; $display("FAIL t4_count32 got=%0d exp=4", outs);
    end
    q32.delete();
  endtask

  // T5: flush with 3 in flight; the op leaving that cycle still counts, the
  // op accepted that cycle is dropped.
  task automatic test_flush();
    logic [1:0] op; logic [31:0] a, b; exp_t e;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      drive32(1, op, a, b, 6'(30 + c), 1, 0);
      #1;
      q32.push_back('{wid: 6'(30 + c), res: ref_mul(32, op, {32'd0, a}, {32'd0, b})});
    end
    @(negedge clk);
    drive32(1, 2'b00, $urandom, $urandom, 6'd40, 1, 1);
    #1;
    checks++;
    if (b32.ready_o !== 1'b1) begin
      failures++; $display("FAIL t5_ready32 got=%b exp=1", b32.ready_o);
    end
    e = q32.pop_front();
    checks++;
    if ({b32.valid_o, b32.wid_o, b32.result_o} !== {1'b1, e.wid, e.res[31:0]}) begin
      failures++; $display("FAIL t5_last_out32 got v=%b wid=%0d res=%h exp v=1 wid=%0d res=%h", b32.valid_o, b32.wid_o, b32.result_o, e.wid, e.res[31:0]);
    end
    q32.delete();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive32(0, 2'b00, 0, 0, 0, 1, 0);
      #1;
      checks++;
      if (b32.valid_o !== 1'b0 || (c == 0 && b32.busy_o !== 1'b0)) begin
        failures++; $display("FAIL t5_empty32 cycle=%0d got v=%b busy=%b wid=%0d exp v=0 busy=0", c, b32.valid_o, b32.busy_o, b32.wid_o);
      end
    end
  endtask

  // T6: reset pulse mid-stream, then a fresh op at full latency.
  task automatic test_reset_mid();
    logic [1:0] op; logic [31:0] a, b; logic [31:0] ex; int lat;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive32(1, 2'b01, $urandom, $urandom, 6'(44 + c), 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    drive32(0, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    ex = 32'(ref_mul(32, op, {32'd0, a}, {32'd0, b}));
    drive32(1, op, a, b, 6'd50, 1, 0);
    #1;
    checks++;
    if ({b32.valid_o, b32.busy_o, b32.wid_o, b32.result_o} !== 40'd0) begin
      failures++; $display("FAIL t6_reset32 got v=%b busy=%b wid=%0d res=%h exp 0", b32.valid_o, b32.busy_o, b32.wid_o, b32.result_o);
    end
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      b32.valid_i = 1'b0;
      #1;
      if (b32.valid_o) lat = c;
    end
    checks++;
    if (lat != 3 || {b32.wid_o, b32.result_o} !== {6'd50, ex}) begin
      failures++; $display("FAIL t6_after32 got lat=%0d wid=%0d res=%h exp lat=3 wid=50 res=%h", lat, b32.wid_o, b32.result_o, ex);
    end
  endtask

  task automatic test_t1_64();
    logic [63:0] m1 = 64'hFFFF_FFFF_FFFF_FFFF;
    logic [1:0]  op[6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11};
    logic [63:0] av[6] = '{m1, m1, m1, m1, 64'd2, m1};
    logic [63:0] bv[6] = '{64'd2, 64'd2, 64'd2, 64'd2, m1, m1};
    logic [63:0] ex[6] = '{64'hFFFF_FFFF_FFFF_FFFE, m1, 64'd1, m1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE};
    int lat;
    drive32(0, 2'b00, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive64(1, op[i], av[i], bv[i], 6'(i), 1, 0);
      #1;
      lat = 0;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
        @(negedge clk);
        b64.valid_i = 1'b0;
        #1;
        if (b64.valid_o) lat = c;
      end
      checks++;
      if (lat != 4 || {b64.wid_o, b64.result_o} !== {6'(i), ex[i]}) begin
        failures++; $display("FAIL t1_result64 op=%0d got lat=%0d wid=%0d res=%h exp lat=4 wid=%0d res=%h", i, lat, b64.wid_o, b64.result_o, i, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back_64();
    logic [1:0] op; logic [63:0] a, b; exp_t e;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      op = 2'($urandom_range(0, 3)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      drive64(c < 8, op, a, b, 6'(c), 1, 0);
      #1;
      if (c < 8) q64.push_back('{wid: 6'(c), res: ref_mul(64, op, a, b)});
      checks++;
      if (b64.valid_o !== (c >= 4 && c < 12)) begin
        failures++; $display("FAIL t2_valid64 cycle=%0d got=%b exp=%b", c, b64.valid_o, (c >= 4 && c < 12));
      end
      if (b64.valid_o && q64.size() > 0) begin
        e = q64.pop_front();
        checks++;
        if ({b64.wid_o, b64.result_o} !== {e.wid, e.res}) begin
          failures++; $display("FAIL t2_data64 cycle=%0d got wid=%0d res=%h exp wid=%0d res=%h", c, b64.wid_o, b64.result_o, e.wid, e.res);
        end
      end
    end
    checks++;
    if (q64.size() != 0) begin
      failures++; $display("FAIL t2_drain64 got left=%0d exp=0", q64.size());
    end
    q64.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_t1();
    test_back_to_back();
    test_stall();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_t1_64();
    test_back_to_back_64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
